// File: rtl/arp_cache_pkg.sv
// arp_cache_pkg: shared types for the ARP cache table and its miss controller.
// Age width is sized for the default age limit; larger limits need AGE_LIMIT_DEF raised.
package arp_cache_pkg;

    localparam int AGE_LIMIT_DEF = 60000;
    localparam int AGE_W         = $clog2(AGE_LIMIT_DEF + 1);

    typedef struct packed {
        logic             valid;
        logic [31:0]      ip;
        logic [47:0]      mac;
        logic [AGE_W-1:0] age;
    } arp_entry_t;

    typedef enum logic [1:0] {
        MISS_IDLE,
        MISS_REQ,
        MISS_WAIT,
        MISS_FAIL
    } miss_state_t;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/arp_cache_table_miss_ctrl.sv
// arp_miss_ctrl: single outstanding ARP resolution with tick-timed retries.
// Issues a request per attempt and reports failure once attempts run out.
module arp_miss_ctrl
    import arp_cache_pkg::*;
#(
    parameter int P_RETRY_TICKS = 100,
    parameter int P_RETRY_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        flush,
    input  logic        seek_done,
    input  logic        seek_hit,
    input  logic [31:0] seek_ip,
    input  logic        learn_valid,
    input  logic [31:0] learn_ip,
    output logic        arp_active,
    output logic [31:0] arp_dst_ip,
    output logic        resolve_fail,
    output logic [31:0] fail_ip
);

    localparam int RT_W = $clog2(P_RETRY_TICKS + 1);
    localparam int RC_W = $clog2(P_RETRY_MAX + 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(P_RETRY_TICKS - 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(P_RETRY_MAX);

    miss_state_t     state;
    logic [31:0]     pend_ip;
    logic [RC_W-1:0] retry_cnt;
    logic [RT_W-1:0] wait_ticks;
    logic            resolved;

    // The pending IP is resolved by ARP RX or by a lookup that found it.
    assign resolved = (learn_valid && learn_ip == pend_ip) ||
                      (seek_done && seek_hit && seek_ip == pend_ip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= MISS_IDLE;
            pend_ip      <= '0;
            retry_cnt    <= '0;
            wait_ticks   <= '0;
            arp_active   <= 1'b0;
            arp_dst_ip   <= '0;
            resolve_fail <= 1'b0;
            fail_ip      <= '0;
        end else begin
            arp_active   <= 1'b0;
            resolve_fail <= 1'b0;
            if (flush) begin
                state      <= MISS_IDLE;
                retry_cnt  <= '0;
                wait_ticks <= '0;
            end else begin
                unique case (state)
                    MISS_IDLE: begin
                        if (seek_done && !seek_hit) begin
                            pend_ip   <= seek_ip;
                            retry_cnt <= '0;
                            state     <= MISS_REQ;
                        end
                    end
                    MISS_REQ: begin
                        arp_active <= 1'b1;
                        arp_dst_ip <= pend_ip;
                        retry_cnt  <= retry_cnt + 1'b1;
                        wait_ticks <= '0;
                        state      <= MISS_WAIT;
                    end
                    MISS_WAIT: begin
                        if (resolved) begin
                            state <= MISS_IDLE;
                        end else if (tick) begin
                            if (wait_ticks == RT_LAST) begin
                                wait_ticks <= '0;
                                state <= (retry_cnt < RC_MAX) ?
                                         MISS_REQ : MISS_FAIL;
                            end else begin
                                wait_ticks <= wait_ticks + 1'b1;
                            end
                        end
                    end
                    MISS_FAIL: begin
                        resolve_fail <= 1'b1;
                        fail_ip      <= pend_ip;
                        state        <= MISS_IDLE;
                    end
                    default: state <= MISS_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/arp_cache_table.sv
// arp_cache_table: IP->MAC cache with aging, flush and ARP miss resolution.
// Define ARP_CACHE_STATS_EN to add hit/miss/evict counter outputs.
module arp_cache_table
    import arp_cache_pkg::*;
#(
    parameter int P_DEPTH       = 8,
    parameter int P_TICK_CYCLES = 156250,
    parameter int P_AGE_LIMIT   = 60000,
    parameter int P_RETRY_TICKS = 100,
    parameter int P_RETRY_MAX   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_learn_ip,
    input  logic [47:0] i_learn_mac,
    input  logic        i_learn_valid,
    input  logic [31:0] i_seek_ip,
    input  logic        i_seek_valid,
    output logic [47:0] o_seek_mac,
    output logic        o_seek_hit,
    output logic        o_seek_miss,
    output logic        o_arp_active,
    output logic [31:0] o_arp_active_dst_ip,
    output logic        o_resolve_fail,
    output logic [31:0] o_fail_ip,
    input  logic        i_flush
`ifdef ARP_CACHE_STATS_EN
    ,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt,
    output logic [31:0] o_evict_cnt
`endif
);

    localparam int IDX_W  = $clog2(P_DEPTH);
    localparam int TICK_W = (P_TICK_CYCLES > 1) ? $clog2(P_TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(P_TICK_CYCLES - 1);
    localparam logic [AGE_W-1:0]  AGE_LIM   = AGE_W'(P_AGE_LIMIT);

    arp_entry_t [P_DEPTH-1:0] tbl;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic              learn_found;
    logic              free_found;
    logic [IDX_W-1:0]  learn_idx;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  old_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [AGE_W-1:0]  old_age;
    logic              seek_found;
    logic [47:0]       seek_mac;

    logic              s1_valid;
    logic              s1_hit;
    logic [31:0]       s1_ip;
    logic [47:0]       s1_mac;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Oldest-entry search uses strict '>' so ties keep the lowest index.
    always_comb begin
        learn_found = 1'b0;
        learn_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        old_idx     = '0;
        old_age     = '0;
        seek_found  = 1'b0;
        seek_mac    = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (tbl[i].valid) begin
                if (!learn_found && tbl[i].ip == i_learn_ip) begin
                    learn_found = 1'b1;
                    learn_idx   = IDX_W'(i);
                end
                if (tbl[i].age > old_age) begin
                    old_age = tbl[i].age;
                    old_idx = IDX_W'(i);
                end
                if (tbl[i].ip == i_seek_ip) begin
                    seek_found = 1'b1;
                    seek_mac   = seek_mac | tbl[i].mac;
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign wr_idx = learn_found ? learn_idx :
                    free_found  ? free_idx  : old_idx;

    // Learn is written after aging so a same-cycle learn restarts at age 0.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tbl <= '0;
        end else if (i_flush) begin
            tbl <= '0;
        end else begin
            for (int i = 0; i < P_DEPTH; i++) begin
                if (tick && tbl[i].valid) begin
                    tbl[i].age <= age_inc(tbl[i].age);
                    if (age_inc(tbl[i].age) == AGE_LIM) begin
                        tbl[i].valid <= 1'b0;
                    end
                end
            end
            if (i_learn_valid) begin
                tbl[wr_idx] <= '{valid: 1'b1,
                                 ip:    i_learn_ip,
                                 mac:   i_learn_mac,
                                 age:   '0};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid    <= 1'b0;
            s1_hit      <= 1'b0;
            s1_ip       <= '0;
            s1_mac      <= '0;
            o_seek_hit  <= 1'b0;
            o_seek_miss <= 1'b0;
            o_seek_mac  <= '0;
        end else begin
            s1_valid    <= i_seek_valid;
            s1_hit      <= i_seek_valid && seek_found;
            s1_ip       <= i_seek_valid ? i_seek_ip : '0;
            s1_mac      <= i_seek_valid ? seek_mac : '0;
            o_seek_hit  <= s1_valid && s1_hit;
            o_seek_miss <= s1_valid && !s1_hit;
            o_seek_mac  <= s1_mac;
        end
    end

    // The controller watches stage 1 so a request follows o_seek_miss by one cycle.
    arp_miss_ctrl #(
        .P_RETRY_TICKS (P_RETRY_TICKS),
        .P_RETRY_MAX   (P_RETRY_MAX)
    ) u_miss_ctrl (
        .clk          (i_clk),
        .rst_n        (i_rst),
        .tick         (tick),
        .flush        (i_flush),
        .seek_done    (s1_valid),
        .seek_hit     (s1_hit),
        .seek_ip      (s1_ip),
        .learn_valid  (i_learn_valid),
        .learn_ip     (i_learn_ip),
        .arp_active   (o_arp_active),
        .arp_dst_ip   (o_arp_active_dst_ip),
        .resolve_fail (o_resolve_fail),
        .fail_ip      (o_fail_ip)
    );

`ifdef ARP_CACHE_STATS_EN
    logic [31:0] aged_n;
    logic        evict_now;

    assign evict_now = i_learn_valid && !learn_found && !free_found;

    // A slot rewritten by learn this cycle is not an age-out.
    always_comb begin
        aged_n = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (tick && tbl[i].valid &&
                age_inc(tbl[i].age) == AGE_LIM &&
                !(i_learn_valid && wr_idx == IDX_W'(i))) begin
                aged_n = aged_n + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_hit_cnt   <= '0;
            o_miss_cnt  <= '0;
            o_evict_cnt <= '0;
        end else if (i_flush) begin
            o_hit_cnt   <= '0;
            o_miss_cnt  <= '0;
            o_evict_cnt <= '0;
        end else begin
            if (s1_valid && s1_hit) begin
                o_hit_cnt <= o_hit_cnt + 32'd1;
            end
            if (s1_valid && !s1_hit) begin
                o_miss_cnt <= o_miss_cnt + 32'd1;
            end
            if (i_flush == 1'b0) begin
                o_evict_cnt <= o_evict_cnt + aged_n + {31'd0, evict_now};
            end
        end
    end
`endif

endmodule

// File: tb/tb_arp_cache_table.sv
// tb_arp_cache_table: directed checks of lookup, learn, eviction, aging and miss handling.
// Small tick/age/retry parameters keep every scenario within a few dozen cycles.
module tb_arp_cache_table;

    localparam int DEPTH = 4;
    localparam int TICKC = 4;
    localparam int AGEL  = 3;
    localparam int RT    = 2;
    localparam int RM    = 3;

    localparam logic [31:0] IP_A = 32'hC0A86401;
    localparam logic [31:0] IP_N = 32'hC0A86407;
    localparam logic [31:0] IP_B = 32'hC0A86402;
    localparam logic [31:0] IP_C = 32'hC0A86403;
    localparam logic [31:0] IP_D = 32'hC0A86404;
    localparam logic [31:0] IP_E = 32'hC0A86405;
    localparam logic [47:0] MAC_A  = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] MAC_A2 = 48'h112233445566;
    localparam logic [47:0] MAC_B  = 48'h0000000000B1;
    localparam logic [47:0] MAC_C  = 48'h0000000000C1;
    localparam logic [47:0] MAC_D  = 48'h0000000000D1;
    localparam logic [47:0] MAC_E  = 48'h0000000000E1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_learn_ip = '0;
    logic [47:0] i_learn_mac = '0;
    logic        i_learn_valid = 1'b0;
    logic [31:0] i_seek_ip = '0;
    logic        i_seek_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic [47:0] o_seek_mac;
    logic        o_seek_hit;
    logic        o_seek_miss;
    logic        o_arp_active;
    logic [31:0] o_arp_active_dst_ip;
    logic        o_resolve_fail;
    logic [31:0] o_fail_ip;

    always #5 i_clk = ~i_clk;

    arp_cache_table #(
        .P_DEPTH       (DEPTH),
        .P_TICK_CYCLES (TICKC),
        .P_AGE_LIMIT   (AGEL),
        .P_RETRY_TICKS (RT),
        .P_RETRY_MAX   (RM)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_learn_ip          (i_learn_ip),
        .i_learn_mac         (i_learn_mac),
        .i_learn_valid       (i_learn_valid),
        .i_seek_ip           (i_seek_ip),
        .i_seek_valid        (i_seek_valid),
        .o_seek_mac          (o_seek_mac),
        .o_seek_hit          (o_seek_hit),
        .o_seek_miss         (o_seek_miss),
        .o_arp_active        (o_arp_active),
        .o_arp_active_dst_ip (o_arp_active_dst_ip),
        .o_resolve_fail      (o_resolve_fail),
        .o_fail_ip           (o_fail_ip),
        .i_flush             (i_flush)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rel    = 0;

    string       sb_tag[$];
    bit          sb_hit[$];
    logic [47:0] sb_mac[$];
    int          sb_edge[$];

    int          act_n = 0;
    int          act_edge[16];
    logic [31:0] act_ip = '0;
    int          fail_n = 0;
    int          fail_edge = 0;
    logic [31:0] fail_ip_s = '0;

    string       m_tag;
    bit          m_hit;
    logic [47:0] m_mac;
    int          m_edge;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge i_clk) edge_n <= edge_n + 1;

    always @(negedge i_clk) begin
        if (i_rst) begin
            if (o_seek_hit || o_seek_miss) begin
                if (sb_tag.size() == 0) begin
                    check("sb_underflow", sb_tag.size(), 1);
                end else begin
                    m_tag  = sb_tag.pop_front();
                    m_hit  = sb_hit.pop_front();
                    m_mac  = sb_mac.pop_front();
                    m_edge = sb_edge.pop_front();
                    check({m_tag, ".strobe"}, {o_seek_hit, o_seek_miss},
                          m_hit ? 2'b10 : 2'b01);
                    check({m_tag, ".mac"}, o_seek_mac, m_mac);
                    check({m_tag, ".lat"}, edge_n, m_edge);
                end
            end
            if (o_arp_active) begin
                if (act_n < 16) act_edge[act_n] = edge_n;
                act_ip = o_arp_active_dst_ip;
                act_n++;
            end
            if (o_resolve_fail) begin
                fail_edge = edge_n;
                fail_ip_s = o_fail_ip;
                fail_n++;
            end
        end
    end

    task automatic drive(input bit lv, input logic [31:0] lip,
                         input logic [47:0] lmac, input bit sv,
                         input logic [31:0] sip, input bit fl);
        i_learn_valid = lv;
        i_learn_ip    = lip;
        i_learn_mac   = lmac;
        i_seek_valid  = sv;
        i_seek_ip     = sip;
        i_flush       = fl;
        @(negedge i_clk);
        i_learn_valid = 1'b0;
        i_seek_valid  = 1'b0;
        i_flush       = 1'b0;
    endtask

    task automatic expect_seek(input string tag, input bit h,
                               input logic [47:0] m);
        sb_tag.push_back(tag);
        sb_hit.push_back(h);
        sb_mac.push_back(m);
        sb_edge.push_back(edge_n + 2);
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        drive(1'b1, ip, mac, 1'b0, '0, 1'b0);
    endtask

    task automatic seek(input string tag, input logic [31:0] ip,
                        input bit h, input logic [47:0] m);
        expect_seek(tag, h, m);
        drive(1'b0, '0, '0, 1'b1, ip, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b0;
        i_learn_valid = 1'b0;
        i_seek_valid  = 1'b0;
        i_flush       = 1'b0;
        #1;
        check({tag, ".rst_hit"},  o_seek_hit, 0);
        check({tag, ".rst_miss"}, o_seek_miss, 0);
        check({tag, ".rst_mac"},  o_seek_mac, 0);
        check({tag, ".rst_act"},  o_arp_active, 0);
        check({tag, ".rst_dst"},  o_arp_active_dst_ip, 0);
        check({tag, ".rst_fail"}, o_resolve_fail, 0);
        check({tag, ".rst_fip"},  o_fail_ip, 0);
        check({tag, ".sb_left"},  sb_tag.size(), 0);
        sb_tag.delete();
        sb_hit.delete();
        sb_mac.delete();
        sb_edge.delete();
        act_n  = 0;
        fail_n = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        rel = edge_n;
    endtask

    initial begin
        #2;
        // basic learn then lookup, then overwrite of a present IP
        do_reset("t1");
        learn(IP_A, MAC_A);
        seek("t1_hit", IP_A, 1'b1, MAC_A);
        idle(3);
        learn(IP_A, MAC_A2);
        seek("t1_upd", IP_A, 1'b1, MAC_A2);
        idle(3);

        // miss, request one cycle after the miss strobe, answered in WAIT
        do_reset("t2");
        seek("t2_miss", IP_N, 1'b0, '0);
        idle(3);
        learn(IP_N, MAC_B);
        seek("t2_after", IP_N, 1'b1, MAC_B);
        idle(40);
        check("t2_act_n", act_n, 1);
        check("t2_act_edge", act_edge[0], rel + 3);
        check("t2_act_ip", act_ip, IP_N);
        check("t2_fail_n", fail_n, 0);

        // unanswered miss: three requests then one failure
        do_reset("t3");
        seek("t3_miss", IP_E, 1'b0, '0);
        idle(35);
        check("t3_act_n", act_n, RM);
        check("t3_act0", act_edge[0], rel + 3);
        check("t3_act1", act_edge[1], rel + 9);
        check("t3_act2", act_edge[2], rel + 17);
        check("t3_act_ip", act_ip, IP_E);
        check("t3_fail_n", fail_n, 1);
        check("t3_fail_edge", fail_edge, rel + 25);
        check("t3_fail_ip", fail_ip_s, IP_E);

        // full table: oldest entry (A, age 2) replaced by E
        do_reset("t4");
        learn(IP_A, MAC_A);
        idle(3);
        learn(IP_B, MAC_B);
        idle(3);
        learn(IP_C, MAC_C);
        learn(IP_D, MAC_D);
        learn(IP_E, MAC_E);
        seek("t4_b", IP_B, 1'b1, MAC_B);
        seek("t4_c", IP_C, 1'b1, MAC_C);
        seek("t4_d", IP_D, 1'b1, MAC_D);
        seek("t4_e", IP_E, 1'b1, MAC_E);
        seek("t4_a", IP_A, 1'b0, '0);
        idle(4);

        // aging: X expires after three ticks, Y relearned on every tick
        do_reset("t5");
        learn(IP_C, MAC_C);
        learn(IP_D, MAC_D);
        idle(1);
        learn(IP_D, MAC_D);
        idle(3);
        learn(IP_D, MAC_D);
        idle(2);
        seek("t5_x_live", IP_C, 1'b1, MAC_C);
        learn(IP_D, MAC_D);
        seek("t5_x_aged", IP_C, 1'b0, '0);
        seek("t5_y_a", IP_D, 1'b1, MAC_D);
        idle(1);
        learn(IP_D, MAC_D);
        seek("t5_y_b", IP_D, 1'b1, MAC_D);
        idle(3);

        // same-cycle learn/seek misses; flush clears table and aborts FSM
        do_reset("t6");
        expect_seek("t6_same", 1'b0, '0);
        drive(1'b1, IP_B, MAC_B, 1'b1, IP_B, 1'b0);
        seek("t6_next", IP_B, 1'b1, MAC_B);
        learn(IP_C, MAC_C);
        idle(2);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        seek("t6_fl_b", IP_B, 1'b0, '0);
        seek("t6_fl_c", IP_C, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(40);
        check("t6_act_n", act_n, 2);
        check("t6_act0", act_edge[0], rel + 3);
        check("t6_act1", act_edge[1], rel + 9);
        check("t6_fail_n", fail_n, 0);

        // reset while waiting: outputs clear, nothing resumes afterwards
        do_reset("t7");
        seek("t7_miss", IP_A, 1'b0, '0);
        idle(4);
        check("t7_act_n_pre", act_n, 1);
        do_reset("t7b");
        idle(40);
        check("t7_act_n", act_n, 0);
        check("t7_fail_n", fail_n, 0);

        check("sb_empty", sb_tag.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
